// File: rtl/fakeram130_1rw_param.sv
// fakeram130_1rw_param: parametrised single-port 1RW fake SRAM with a bit-granular write mask
// and a post-reset zeroing sweep.
// Latency: a read is accepted at a clock edge, and its data appears on rd_out READ_LATENCY
// (1 or 2) cycles later. Any value other than 2 behaves as 1.
// Backpressure: none. ready_out low means the access inputs are ignored, and nothing is queued.
//
// Ports:
//   clk          - clock; all state updates happen on posedge
//   reset_in     - synchronous active-high reset; it takes priority over any access
//   ce_in/we_in  - access enable and write select (1 = write, 0 = read)
//   addr_in      - word address; addresses >= WORD_DEPTH drop writes and read back zero
//   wd_in        - write data
//   w_mask_in    - per-bit write enable (1 = write that bit)
//   rd_out       - registered read data; it holds its value between results
//   rd_valid_out - one-cycle strobe: rd_out carries a new result
//   ready_out    - the zeroing sweep is finished and accesses are accepted
//
// Optional build macro FAKERAM130_WRITE_THROUGH_EN: a write also returns the merged
// post-write word on rd_out (with rd_valid_out) at READ_LATENCY. Array contents are the
// same with or without the macro.
module fakeram130_1rw_param #(
  parameter int BITS               = 46,
  parameter int WORD_DEPTH         = 1024,
  parameter int ADDR_WIDTH         = $clog2(WORD_DEPTH),
  parameter int READ_LATENCY       = 1,
  parameter int CLEAR_ON_RESET     = 1,
  parameter int corrupt_mem_on_X_p = 1
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  ce_in,
  input  logic                  we_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [BITS-1:0]       wd_in,
  input  logic [BITS-1:0]       w_mask_in,
  output logic [BITS-1:0]       rd_out,
  output logic                  rd_valid_out,
  output logic                  ready_out
);

  // One extra bit so that depths which fill the whole address space still compare correctly.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clear_we;

  logic [BITS-1:0]       mem [WORD_DEPTH];

  logic                  x_any;
  logic                  x_hit;
  logic                  acc;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  in_range;
  logic [BITS-1:0]       word_rd;
  logic [BITS-1:0]       merged;
  logic [BITS-1:0]       wt_dat;
  logic                  s1_load;
  logic [BITS-1:0]       s1_nxt;
  logic                  s1_vld;
  logic [BITS-1:0]       s1_dat;

  // ---------------------------------------------------------------------------
  // Sequencer. The state register comes first; the next-state logic follows.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clear_we  = 1'b0;
    ready_out = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          // Zero one word per cycle. Move to ready on the same edge that writes the last word.
          clear_we = 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        // ready_out is masked by reset_in. An access presented together with reset is never
        // seen as accepted.
        ready_out = ~reset_in;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  // X on the access controls exists only in 4-state simulation.
  // When corruption is enabled, such an access poisons the whole array. When it is
  // disabled, the access is dropped as a no-op.
  assign x_any    = $isunknown(ce_in) || (ce_in && $isunknown({we_in, addr_in}));
  assign x_hit    = (corrupt_mem_on_X_p != 0) && ready_out && x_any;
  assign acc      = ready_out && ce_in && !x_any;
  assign acc_rd   = acc && !we_in;
  assign acc_wr   = acc && we_in;
  assign in_range = ({1'b0, addr_in} < DEPTH_W);

  // The array updates at the write edge. A read in the next cycle therefore sees the new
  // word with no bypass logic.
  assign word_rd  = in_range ? mem[addr_in] : '0;
  assign merged   = (word_rd & ~w_mask_in) | (wd_in & w_mask_in);
  // A dropped out-of-range write reports zeros, matching what a read of that address returns.
  assign wt_dat   = in_range ? merged : '0;

`ifdef FAKERAM130_WRITE_THROUGH_EN
  assign s1_load  = acc;
`else
  assign s1_load  = acc_rd;
`endif
  assign s1_nxt   = acc_wr ? wt_dat : word_rd;

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // The storage array has no reset of its own. Zeroing is done by the sweep, which only
  // runs in cycles where reset_in is low.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      if (x_hit) begin
        for (int i = 0; i < WORD_DEPTH; i++) begin
          mem[i] <= 'x;
        end
      end else if (clear_we) begin
        mem[cnt_q] <= '0;
      end else if (acc_wr && in_range) begin
        mem[addr_in] <= merged;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  // Stage 1 captures data at the request edge. Its data register loads only when it
  // carries a result, so the output holds its value while idle.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else if (x_hit) begin
      s1_vld <= 1'b0;
      s1_dat <= 'x;
    end else begin
      s1_vld <= s1_load;
      if (s1_load) begin
        s1_dat <= s1_nxt;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic            s2_vld;
      logic [BITS-1:0] s2_dat;

      // Reset clears both valid bits. A read still in flight is therefore discarded.
      always_ff @(posedge clk) begin
        if (reset_in) begin
          s2_vld <= 1'b0;
          s2_dat <= '0;
        end else if (x_hit) begin
          s2_vld <= 1'b0;
          s2_dat <= 'x;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_dat <= s1_dat;
          end
        end
      end

      assign rd_out       = s2_dat;
      assign rd_valid_out = s2_vld;
    end else begin : g_lat1
      assign rd_out       = s1_dat;
      assign rd_valid_out = s1_vld;
    end
  endgenerate

endmodule

// File: doc/fakeram130_1rw_param.md
Name: fakeram130_1rw_param

Overview:
Parametrised, synthesizable-for-sim single-port 1RW fake SRAM that replaces per-size fakeram130 black boxes in manycore and testsuite builds. Configurable width, depth and read latency, with bit-granular write mask. Adds a post-reset zeroing sequencer with a ready flag and a read-valid strobe, which the fixed-size macros lack. Sits wherever a hard SRAM macro is instantiated: tile dmem/icache and vcache data/tag arrays.

Parameters:
BITS, 46, word width in bits (>=1)
WORD_DEPTH, 1024, number of words (>=2; need not be a power of 2)
ADDR_WIDTH, $clog2(WORD_DEPTH), address width
READ_LATENCY, 1, cycles from accepted read to rd_out valid; legal values 1 or 2 only
CLEAR_ON_RESET, 1, 1 = sweep all words to zero after reset; 0 = contents untouched
corrupt_mem_on_X_p, 1, 1 = X on ce_in/we_in/addr_in during an access writes X to every word (sim only)

Ports:
clk  input  1  clock; all state updates on posedge
reset_in  input  1  synchronous active-high reset
ce_in  input  1  access enable
we_in  input  1  1 = write, 0 = read (qualified by ce_in)
addr_in  input  ADDR_WIDTH  word address
wd_in  input  BITS  write data
w_mask_in  input  BITS  per-bit write enable, 1 = write the bit
rd_out  output  BITS  read data (registered)
rd_valid_out  output  1  1-cycle strobe: rd_out carries a new result
ready_out  output  1  1 = accesses accepted

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset_in), sampled only at posedge clk.
- While reset_in=1:
  - state=CLEAR, clear counter=0
  - rd_out=0, rd_valid_out=0, ready_out=0
  - pipeline valid bits cleared; any in-flight read is discarded
- States:
  - CLEAR: entered on reset. If CLEAR_ON_RESET=1, writes 0 to word[cnt] each cycle, cnt 0..WORD_DEPTH-1, for exactly WORD_DEPTH cycles after reset deasserts; ready_out rises on the cycle after the last word (cnt=WORD_DEPTH-1) is written. If CLEAR_ON_RESET=0, CLEAR lasts one cycle.
  - READY: ready_out=1; stays in READY until the next reset.
- ce_in, we_in, addr_in, wd_in and w_mask_in are ignored while ready_out=0. There is no backpressure and no queuing.
- Write (ready, ce_in=1, we_in=1): at the edge, word[a] = (word[a] & ~w_mask_in) | (wd_in & w_mask_in). rd_out holds its value and rd_valid_out=0 for this access (overridden by the optional feature).
- Read (ready, ce_in=1, we_in=0):
  - READ_LATENCY=1: word[a] is captured into rd_out at the request edge and rd_valid_out=1 for the following cycle.
  - READ_LATENCY=2: one extra register stage; rd_out and rd_valid_out lag by one more cycle.
  - Back-to-back reads are fully pipelined: 1 result per cycle.
- Idle (ce_in=0): rd_out holds its value; rd_valid_out=0 once the pipeline drains.
- Out-of-range address (addr_in >= WORD_DEPTH, non-power-of-2 depth only): writes are dropped; reads return all zeros with normal latency and valid.
- Read and write to the same address in consecutive cycles: the read sees the updated word. There is no hazard because the array update completes at the write edge.
- Reset mid-operation, including mid-CLEAR:
  - takes priority over any access
  - restarts CLEAR from cnt=0
  - rd_valid_out=0 the cycle after reset is sampled
  - no result of a pre-reset read ever appears
- X handling: if corrupt_mem_on_X_p=1 and ce_in=1 with X on we_in or addr_in, every word is set to X and rd_out is set to X. If corrupt_mem_on_X_p=0, the access is treated as a no-op.

Optional Feature:
- Macro FAKERAM130_WRITE_THROUGH_EN.
- Defined: a write also returns the merged post-write word on rd_out, with rd_valid_out=1, at READ_LATENCY (write-first behaviour, matching macros with read-during-write output).
- Undefined: writes produce no read result; rd_out holds and rd_valid_out=0, as specified above.
- Array contents are identical either way.

Test Plan:
- Reset high 2 cycles, then low, CLEAR_ON_RESET=1, WORD_DEPTH=16 -> ready_out=0 for 16 cycles, 1 on cycle 17; reads of addr 0..15 all return 0 with rd_valid_out=1.
- Write addr 5 wd=46'h3FFF_FFFF_FFFF mask=all 1s; then write addr 5 wd=0 mask=46'hFF; read addr 5 -> rd_out=46'h3FFF_FFFF_FF00, one cycle after the read with READ_LATENCY=1 and two cycles after with READ_LATENCY=2.
- Reads of addr 1,2,3 back-to-back (words preloaded 0xA,0xB,0xC), then ce_in=0 -> rd_out 0xA,0xB,0xC on consecutive cycles with rd_valid_out=1, then rd_valid_out=0 and rd_out holds 0xC.
- WORD_DEPTH=20: write addr 25 data 0x1, then read addr 25 and read addr 19 -> read 25 returns 0 with valid=1; addr 19 unchanged.
- Issue a read at READ_LATENCY=2, assert reset_in on the next cycle -> rd_valid_out never pulses for that read; ready_out=0 and the CLEAR sweep restarts.
- With FAKERAM130_WRITE_THROUGH_EN defined: write addr 7 wd=0x55 mask=0x0F over old 0xA0 -> rd_out=0xA5 and rd_valid_out=1 at READ_LATENCY. Undefined: rd_valid_out=0 and rd_out holds.
